regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds default widths, the hard-wired zero register and the requester id.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grants from the requests
// and a priority pointer that moves past whichever requester was just granted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    i_req_a,
  input  logic    i_req_b,
  output logic    o_gnt_a,
  output logic    o_gnt_b,
  output req_id_t o_ptr
);

  req_id_t r_ptr;
  logic    w_req_a;
  logic    w_req_b;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_req_a = i_req_a & ~reset;
    w_req_b = i_req_b & ~reset;
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (w_req_a && w_req_b) begin
      if (r_ptr == REQ_A) o_gnt_a = 1'b1;
      else                o_gnt_b = 1'b1;
    end else begin
      o_gnt_a = w_req_a;
      o_gnt_b = w_req_b;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset)        r_ptr <= REQ_A;
    else if (o_gnt_a) r_ptr <= REQ_B;
    else if (o_gnt_b) r_ptr <= REQ_A;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two register-file write requesters into a single 1-cycle write port.
// Define RF_WRITE_FWD_EN to add write-to-read forwarding outputs.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ReqValidA,
  input  logic [ADDR_W-1:0] ReqRegA,
  input  logic [DATA_W-1:0] ReqDataA,
  output logic              ReqReadyA,
  input  logic              ReqValidB,
  input  logic [ADDR_W-1:0] ReqRegB,
  input  logic [DATA_W-1:0] ReqDataB,
  output logic              ReqReadyB,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              LastGrant,
  output logic [CNT_W-1:0]  DropCount
`ifdef RF_WRITE_FWD_EN
  ,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic              Fwd1,
  output logic              Fwd2,
  output logic [DATA_W-1:0] FwdData
`endif
);

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_xfer;
  logic              w_is_zero;
  req_id_t           w_ptr;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [CNT_W-1:0]  r_drop_count;
  logic              r_seen;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .i_req_a (ReqValidA),
    .i_req_b (ReqValidB),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b),
    .o_ptr   (w_ptr)
  );

  assign w_xfer     = w_gnt_a | w_gnt_b;
  assign w_sel_reg  = w_gnt_b ? ReqRegB  : ReqRegA;
  assign w_sel_data = w_gnt_b ? ReqDataB : ReqDataA;
  assign w_is_zero  = (w_sel_reg == ADDR_W'(ZERO_REG));

  // Register-0 writes are accepted but never reach the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_drop_count <= '0;
      r_seen       <= 1'b0;
    end else begin
      r_reg_write <= w_xfer & ~w_is_zero;
      if (w_xfer) begin
        r_write_reg  <= w_sel_reg;
        r_write_data <= w_sel_data;
        r_seen       <= 1'b1;
        if (w_is_zero && (r_drop_count != '1))
          r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // The pointer always sits on the requester not granted last, so it encodes LastGrant.
  assign LastGrant = r_seen & (w_ptr == REQ_A);

  assign ReqReadyA = w_gnt_a;
  assign ReqReadyB = w_gnt_b;
  assign RegWrite  = r_reg_write;
  assign WriteReg  = r_write_reg;
  assign WriteData = r_write_data;
  assign DropCount = r_drop_count;

`ifdef RF_WRITE_FWD_EN
  assign Fwd1    = r_reg_write & (r_write_reg == Read1) & (Read1 != ADDR_W'(ZERO_REG));
  assign Fwd2    = r_reg_write & (r_write_reg == Read2) & (Read2 != ADDR_W'(ZERO_REG));
  assign FwdData = r_write_data;
`endif

endmodule
